// File: rtl/cwag_pkg.sv
// Shared types and elaboration-time helpers for the convolution window address generator.
package cwag_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int out_dim(input int img, input int pad, input int k, input int stride);
        return (img + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int map_size(input int w, input int h);
        return w * h;
    endfunction

    function automatic bit addr_fits(input int addr_w, input int ch, input int w, input int h);
        return (longint'(ch) * w * h - 1) < (longint'(1) << addr_w);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-LIMIT counter; wrap_o pulses on the enabled step that returns it to zero.
module wrap_counter #(
    parameter int LIMIT = 3,
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign last_o  = (count_q == MAX);
    assign wrap_o  = en_i & last_o;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = last_o ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Streams BRAM read addresses for every KxK window of every output position and channel.
// Zero-pad border support is built only when CWAG_PAD_EN is defined.
module conv_window_addr_gen
    import cwag_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 3,
    parameter int STRIDE   = 1,
    parameter int CHANNELS = 1,
    parameter int PAD      = 0,
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_pad_o,
    output logic              win_last_o,
    output logic              frame_last_o,
    output logic [CNT_W-1:0]  out_row_o,
    output logic [CNT_W-1:0]  out_col_o
);

`ifdef CWAG_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int P     = PAD_EN ? PAD : 0;
    localparam int OUT_W = out_dim(IMG_W, P, K, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, P, K, STRIDE);

    localparam logic [ADDR_W-1:0] IMG_W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP_A = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] MAP_A      = ADDR_W'(map_size(IMG_W, IMG_H));
    localparam logic [CNT_W-1:0]  STRIDE_C   = CNT_W'(STRIDE);

    if (!addr_fits(ADDR_W, CHANNELS, IMG_W, IMG_H)) begin : g_addr_w_check
        $error("ADDR_W too narrow for CHANNELS*IMG_W*IMG_H");
    end

    state_e state_q, state_d;

    logic run, accept, clr;
    logic w_kj, w_ki, w_oj, w_oi, w_ch;
    logic l_kj, l_ki, l_oj, l_oi, l_ch;
    logic [CNT_W-1:0] kj_cnt, ki_cnt, oj_cnt, oi_cnt, ch_cnt;

    // Running sums replace the r*IMG_W / ch*MAP products
    logic [ADDR_W-1:0] krow_q, krow_d;
    logic [ADDR_W-1:0] orow_base_q, orow_base_d;
    logic [ADDR_W-1:0] ch_base_q, ch_base_d;
    logic [CNT_W-1:0]  ocol_q, ocol_d;
    logic [ADDR_W-1:0] lin_sum, addr_raw;
    logic              in_pad;

    assign run    = (state_q == S_RUN);
    assign accept = run & out_ready_i;
    assign clr    = abort_i | ((state_q == S_IDLE) & start_i);

    wrap_counter #(.LIMIT(K), .CNT_W(CNT_W)) u_kj (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr), .en_i(accept),
        .count_o(kj_cnt), .last_o(l_kj), .wrap_o(w_kj)
    );
    wrap_counter #(.LIMIT(K), .CNT_W(CNT_W)) u_ki (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr), .en_i(w_kj),
        .count_o(ki_cnt), .last_o(l_ki), .wrap_o(w_ki)
    );
    wrap_counter #(.LIMIT(OUT_W), .CNT_W(CNT_W)) u_oj (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr), .en_i(w_ki),
        .count_o(oj_cnt), .last_o(l_oj), .wrap_o(w_oj)
    );
    wrap_counter #(.LIMIT(OUT_H), .CNT_W(CNT_W)) u_oi (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr), .en_i(w_oj),
        .count_o(oi_cnt), .last_o(l_oi), .wrap_o(w_oi)
    );
    wrap_counter #(.LIMIT(CHANNELS), .CNT_W(CNT_W)) u_ch (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr), .en_i(w_oi),
        .count_o(ch_cnt), .last_o(l_ch), .wrap_o(w_ch)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i && !abort_i) state_d = S_RUN;
            S_RUN:   if (abort_i) state_d = S_IDLE;
                     else if (w_ch) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        krow_d      = krow_q;
        ocol_d      = ocol_q;
        orow_base_d = orow_base_q;
        ch_base_d   = ch_base_q;
        if (clr) begin
            krow_d      = '0;
            ocol_d      = '0;
            orow_base_d = '0;
            ch_base_d   = '0;
        end else begin
            if (w_kj) krow_d      = w_ki ? '0 : krow_q + IMG_W_A;
            if (w_ki) ocol_d      = w_oj ? '0 : ocol_q + STRIDE_C;
            if (w_oj) orow_base_d = w_oi ? '0 : orow_base_q + ROW_STEP_A;
            if (w_oi) ch_base_d   = w_ch ? '0 : ch_base_q + MAP_A;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            krow_q      <= '0;
            ocol_q      <= '0;
            orow_base_q <= '0;
            ch_base_q   <= '0;
        end else begin
            state_q     <= state_d;
            krow_q      <= krow_d;
            ocol_q      <= ocol_d;
            orow_base_q <= orow_base_d;
            ch_base_q   <= ch_base_d;
        end
    end

    assign lin_sum = ch_base_q + orow_base_q + krow_q + ADDR_W'(ocol_q) + ADDR_W'(kj_cnt);

`ifdef CWAG_PAD_EN
    localparam logic [ADDR_W-1:0]        PAD_OFF_A = ADDR_W'(P * IMG_W + P);
    localparam logic signed [CNT_W+1:0]  P_S       = (CNT_W + 2)'(P);
    localparam logic signed [CNT_W+1:0]  IMG_W_S   = (CNT_W + 2)'(IMG_W);
    localparam logic signed [CNT_W+1:0]  IMG_H_S   = (CNT_W + 2)'(IMG_H);

    logic [CNT_W-1:0]         orow_pos_q, orow_pos_d;
    logic signed [CNT_W+1:0]  r_s, c_s;
    logic                     unused_cnt;

    always_comb begin
        orow_pos_d = orow_pos_q;
        if (clr)
            orow_pos_d = '0;
        else if (w_oj)
            orow_pos_d = w_oi ? '0 : orow_pos_q + STRIDE_C;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            orow_pos_q <= '0;
        else
            orow_pos_q <= orow_pos_d;
    end

    // Window coordinates relative to the unpadded map; negative means top/left border
    assign r_s      = $signed({2'b00, orow_pos_q}) + $signed({2'b00, ki_cnt}) - P_S;
    assign c_s      = $signed({2'b00, ocol_q}) + $signed({2'b00, kj_cnt}) - P_S;
    assign in_pad   = (r_s < 0) | (r_s >= IMG_H_S) | (c_s < 0) | (c_s >= IMG_W_S);
    assign addr_raw = lin_sum - PAD_OFF_A;
    assign unused_cnt = ^ch_cnt;
`else
    logic unused_cnt;
    assign in_pad     = 1'b0;
    assign addr_raw   = lin_sum;
    assign unused_cnt = ^{ki_cnt, ch_cnt};
`endif

    assign busy_o       = run;
    assign done_o       = (state_q == S_DONE);
    assign out_valid_o  = run;
    assign out_pad_o    = run & in_pad;
    assign out_addr_o   = (run && !in_pad) ? addr_raw : '0;
    assign win_last_o   = run & l_ki & l_kj;
    assign frame_last_o = run & l_ki & l_kj & l_oj & l_oi & l_ch;
    assign out_row_o    = oi_cnt;
    assign out_col_o    = oj_cnt;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench: default 3x3/stride-1 generator plus a 2x2/stride-2 two-channel instance.
module tb_conv_window_addr_gen;

    typedef struct packed {
        logic [15:0] addr;
        logic        pad;
        logic        wl;
        logic        fl;
        logic [9:0]  row;
        logic [9:0]  col;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, start1, abort, ready;
    int   sel;

    logic busy0, done0, valid0, pad0, wl0, fl0;
    logic busy1, done1, valid1, pad1, wl1, fl1;
    logic [15:0] addr0, addr1;
    logic [9:0]  row0, col0, row1, col1;

    conv_window_addr_gen u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .abort_i(abort),
        .busy_o(busy0), .done_o(done0), .out_valid_o(valid0), .out_ready_i(ready),
        .out_addr_o(addr0), .out_pad_o(pad0), .win_last_o(wl0), .frame_last_o(fl0),
        .out_row_o(row0), .out_col_o(col0)
    );

    conv_window_addr_gen #(.K(2), .STRIDE(2), .CHANNELS(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .abort_i(abort),
        .busy_o(busy1), .done_o(done1), .out_valid_o(valid1), .out_ready_i(ready),
        .out_addr_o(addr1), .out_pad_o(pad1), .win_last_o(wl1), .frame_last_o(fl1),
        .out_row_o(row1), .out_col_o(col1)
    );

    logic  m_busy, m_done, m_valid;
    beat_t m_beat;
    assign m_busy  = (sel == 0) ? busy0  : busy1;
    assign m_done  = (sel == 0) ? done0  : done1;
    assign m_valid = (sel == 0) ? valid0 : valid1;
    assign m_beat  = (sel == 0) ? {addr0, pad0, wl0, fl0, row0, col0}
                                : {addr1, pad1, wl1, fl1, row1, col1};

    beat_t q[$];
    int checks = 0;
    int passes = 0;

    task automatic push_frame(input int k, input int s, input int nch);
        int oh;
        beat_t b;
        oh = (28 - k) / s + 1;
        for (int c = 0; c < nch; c++)
            for (int oi = 0; oi < oh; oi++)
                for (int oj = 0; oj < oh; oj++)
                    for (int ki = 0; ki < k; ki++)
                        for (int kj = 0; kj < k; kj++) begin
                            b.addr = 16'(c * 784 + (oi * s + ki) * 28 + oj * s + kj);
                            b.pad  = 1'b0;
                            b.wl   = (ki == k - 1) && (kj == k - 1);
                            b.fl   = b.wl && (c == nch - 1) && (oi == oh - 1) && (oj == oh - 1);
                            b.row  = 10'(oi);
                            b.col  = 10'(oj);
                            q.push_back(b);
                        end
    endtask

    task automatic pulse_start(input int dsel);
        @(negedge clk);
        if (dsel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic run_frame(input string name, input int dsel, input int k, input int s,
                             input int nch, input bit rnd, input int abort_at);
        int    beats, cyc, total, dones;
        bit    stalled, aborted;
        beat_t exp_b, snap;
        sel = dsel;
        q.delete();
        push_frame(k, s, nch);
        total = q.size();
        beats = 0; cyc = 0; dones = 0; stalled = 0; aborted = 0;
        pulse_start(dsel);
        while (beats < total && cyc < 40000 && !aborted) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            // a start pulse mid-scan must be ignored
            if (dsel == 0) start0 = (beats == 50); else start1 = (beats == 50);
            if (m_done) dones++;
            checks++;
            if (m_valid !== 1'b1 || m_busy !== 1'b1)
                $display("FAIL %s_valid beat %0d: valid=%b busy=%b, required 1/1", name, beats, m_valid, m_busy);
            else passes++;
            if (stalled) begin
                checks++;
                if (m_beat !== snap)
                    $display("FAIL %s_stall_stable beat %0d: got %h, held %h", name, beats, m_beat, snap);
                else passes++;
            end
            if (ready) begin
                if (beats == abort_at) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end
                exp_b = q.pop_front();
                checks++;
                if (m_beat !== exp_b)
                    $display("FAIL %s_beat %0d: got %h, required %h", name, beats, m_beat, exp_b);
                else passes++;
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                snap = m_beat;
            end
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        abort  = 1'b0;
        ready  = 1'b1;
        if (aborted) begin
            checks++;
            if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_done !== 1'b0)
                $display("FAIL %s_abort_idle: busy=%b valid=%b done=%b, required 0/0/0", name, m_busy, m_valid, m_done);
            else passes++;
            repeat (3) begin
                @(negedge clk);
                if (m_done) dones++;
            end
            checks++;
            if (dones != 0) $display("FAIL %s_abort_no_done: done pulses=%0d, required 0", name, dones);
            else passes++;
            q.delete();
        end else begin
            checks++;
            if (beats != total) $display("FAIL %s_beat_count: got %0d, required %0d", name, beats, total);
            else passes++;
            checks++;
            if (m_done !== 1'b1 || m_busy !== 1'b0 || dones != 0)
                $display("FAIL %s_done_pulse: done=%b busy=%b early=%0d, required 1/0/0", name, m_done, m_busy, dones);
            else passes++;
            @(negedge clk);
            checks++;
            if (m_done !== 1'b0 || m_valid !== 1'b0)
                $display("FAIL %s_done_once: done=%b valid=%b, required 0/0", name, m_done, m_valid);
            else passes++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, valid0, addr0, pad0, wl0, fl0, row0, col0} !== '0)
            $display("FAIL reset_dut0: got %h, required 0", {busy0, done0, valid0, addr0, pad0, wl0, fl0, row0, col0});
        else passes++;
        checks++;
        if ({busy1, done1, valid1, addr1, pad1, wl1, fl1, row1, col1} !== '0)
            $display("FAIL reset_dut1: got %h, required 0", {busy1, done1, valid1, addr1, pad1, wl1, fl1, row1, col1});
        else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0)
            $display("FAIL reset_release_idle: busy=%b valid=%b, required 0/0", busy0, valid0);
        else passes++;
    endtask

    task automatic test_start_abort_idle;
        sel = 1;
        @(negedge clk);
        start1 = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort  = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0)
            $display("FAIL start_abort_idle: busy=%b valid=%b, required 0/0", busy1, valid1);
        else passes++;
    endtask

    task automatic test_reset_midrun;
        sel = 0;
        ready = 1'b1;
        pulse_start(0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, valid0, addr0, pad0, wl0, fl0, row0, col0} !== '0)
            $display("FAIL reset_midrun: got %h, required 0", {busy0, done0, valid0, addr0, pad0, wl0, fl0, row0, col0});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b0; sel = 0;
        test_reset();
        run_frame("back_to_back", 0, 3, 1, 1, 1'b0, -1);
        run_frame("random_stall", 0, 3, 1, 1, 1'b1, -1);
        run_frame("maxpool_2ch", 1, 2, 2, 2, 1'b0, -1);
        run_frame("abort", 1, 2, 2, 2, 1'b0, 100);
        run_frame("restart", 1, 2, 2, 2, 1'b1, -1);
        test_start_abort_idle();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
